// File: rtl/irq_pkg.sv
// irq_pkg: shared state encoding and register map for the interrupt controller.
package irq_pkg;
    typedef enum logic {IDLE, SERVICE} state_t;
    localparam logic [31:0] IMASK_OFS   = 32'd0;
    localparam logic [31:0] IPEND_OFS   = 32'd4;
    localparam logic [31:0] ICAUSE_OFS  = 32'd8;
    localparam int          CAUSE_VALID = 31;
endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: lowest-index-wins priority encoder with an any-request flag.
module irq_prio_enc #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    output logic [2:0]   idx,
    output logic         any
);
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (req[i]) idx = 3'(i);
    end
    assign any = |req;
endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: edge-latched, masked, prioritised interrupt controller with a
// memory-mapped IMASK/IPEND/ICAUSE register block and an in-service tracker.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int          N_SRC     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h4000_0030
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq_src,
    input  logic             kernel_mode,
    input  logic             exception,
    output logic             Interrupt,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    input  logic             wr,
    output logic [31:0]      rdata
);
    state_t           state;
    logic [N_SRC-1:0] irq_q, mask, pend, rise, take_oh, clr;
    logic [2:0]       winner, cause_idx;
    logic             any, take, kmode_q, cause_valid;
    logic             hit_mask, hit_pend, hit_cause;
    logic             unused;

    irq_prio_enc #(.N(N_SRC)) u_enc (
        .req(pend & mask),
        .idx(winner),
        .any(any)
    );

    assign hit_mask  = addr == BASE_ADDR + IMASK_OFS;
    assign hit_pend  = addr == BASE_ADDR + IPEND_OFS;
    assign hit_cause = addr == BASE_ADDR + ICAUSE_OFS;
    assign unused    = ^wdata[31:N_SRC];

    assign rise      = irq_src & ~irq_q;
    assign Interrupt = (state == IDLE) && !kernel_mode && any;
    assign take      = Interrupt && !exception;
    assign take_oh   = take ? (N_SRC'(1) << winner) : '0;
    assign clr       = (wr && hit_pend) ? wdata[N_SRC-1:0] : '0;

    // New edges are OR-ed in last so they beat both W1C and the take clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            irq_q       <= '1;
            kmode_q     <= 1'b1;
            mask        <= '0;
            pend        <= '0;
            cause_valid <= 1'b0;
            cause_idx   <= '0;
        end else begin
            irq_q   <= irq_src;
            kmode_q <= kernel_mode;
            pend    <= (pend & ~clr & ~take_oh) | rise;
            if (wr && hit_mask) mask <= wdata[N_SRC-1:0];
            if (take) begin
                state       <= SERVICE;
                cause_valid <= 1'b1;
                cause_idx   <= winner;
            end else if (state == SERVICE && kmode_q && !kernel_mode) begin
                state <= IDLE;
            end
        end
    end

    always_comb
        rdata = hit_mask  ? 32'(mask) :
                hit_pend  ? 32'(pend) :
                hit_cause ? (32'(cause_valid) << CAUSE_VALID) | 32'(cause_idx) : 32'd0;
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed plan steps plus randomized traffic against a behavioural model.
module tb_irq_ctrl;
    import irq_pkg::*;
    localparam logic [31:0] BASE = 32'h4000_0030;

    logic        clk = 1'b0;
    logic        reset, kernel_mode, exception, wr, Interrupt;
    logic [3:0]  irq_src;
    logic [31:0] addr, wdata, rdata;
    int          checks = 0, errors = 0;

    logic [3:0]  m_mask, m_pend, m_last;
    int          m_cause;
    logic        m_valid, m_busy, m_kprev;

    irq_ctrl #(.N_SRC(4), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .irq_src(irq_src), .kernel_mode(kernel_mode),
        .exception(exception), .Interrupt(Interrupt), .addr(addr),
        .wdata(wdata), .wr(wr), .rdata(rdata)
    );

    always #5 clk = ~clk;

    function automatic logic m_int();
        return !m_busy && !kernel_mode && ((m_pend & m_mask) != 4'd0);
    endfunction

    function automatic logic [31:0] m_rdata();
        if (addr == BASE)     return {28'd0, m_mask};
        if (addr == BASE + 4) return {28'd0, m_pend};
        if (addr == BASE + 8) return {m_valid, 28'd0, 3'(m_cause)};
        return 32'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        logic [3:0] nxt;
        logic       t;
        int         w;
        if (reset) begin
            m_mask = 0; m_pend = 0; m_cause = 0; m_valid = 0;
            m_busy = 0; m_kprev = 1; m_last = 4'hF;
            return;
        end
        t = m_int() && !exception;
        w = -1;
        for (int i = 0; i < 4; i++)
            if (w < 0 && m_pend[i] && m_mask[i]) w = i;
        nxt = m_pend;
        if (wr && addr == BASE + 4) nxt = nxt & ~wdata[3:0];
        if (t) nxt[w] = 1'b0;
        for (int i = 0; i < 4; i++)
            if (irq_src[i] && !m_last[i]) nxt[i] = 1'b1;
        if (wr && addr == BASE) m_mask = wdata[3:0];
        if (t) begin
            m_busy = 1; m_valid = 1; m_cause = w;
        end else if (m_busy && m_kprev && !kernel_mode) begin
            m_busy = 0;
        end
        m_pend  = nxt;
        m_kprev = kernel_mode;
        m_last  = irq_src;
    endtask

    task automatic cmp_model();
        #1;
        chk("interrupt", 32'(Interrupt), 32'(m_int()));
        chk("rdata", rdata, m_rdata());
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic tick();
        cmp_model();
        step();
    endtask

    task automatic wr_reg(input logic [31:0] ofs, input logic [31:0] d);
        addr = BASE + ofs; wdata = d; wr = 1'b1;
        tick();
        wr = 1'b0;
    endtask

    initial begin
        reset = 1; kernel_mode = 0; exception = 0; wr = 0;
        irq_src = 0; addr = 0; wdata = 0;
        step(); step();
        reset = 0;
        cmp_model();
        chk("reset_int", 32'(Interrupt), 32'd0);
        addr = BASE + IPEND_OFS; #1;
        chk("reset_pend", rdata, 32'd0);

        // single source, masked set 0101
        wr_reg(IMASK_OFS, 32'h5);
        irq_src = 4'b0100; addr = BASE + IPEND_OFS;
        tick();
        cmp_model();
        chk("s1_pend", rdata, 32'h4);
        chk("s1_int", 32'(Interrupt), 32'd1);
        step();
        irq_src = 0; addr = BASE + ICAUSE_OFS;
        cmp_model();
        chk("s1_cause", rdata, 32'h8000_0002);
        chk("s1_int_off", 32'(Interrupt), 32'd0);
        addr = BASE + IPEND_OFS; #1;
        chk("s1_pend_clr", rdata, 32'd0);
        kernel_mode = 1; tick();
        kernel_mode = 0; tick();

        // two simultaneous sources, lowest first
        wr_reg(IMASK_OFS, 32'hF);
        irq_src = 4'b1001; addr = BASE + ICAUSE_OFS;
        tick(); tick();
        cmp_model();
        chk("s2_cause0", rdata, 32'h8000_0000);
        kernel_mode = 1; tick();
        kernel_mode = 0;
        cmp_model();
        chk("s2_wait", 32'(Interrupt), 32'd0);
        step();
        cmp_model();
        chk("s2_second", 32'(Interrupt), 32'd1);
        step();
        cmp_model();
        chk("s2_cause3", rdata, 32'h8000_0003);
        kernel_mode = 1; tick();
        kernel_mode = 0; tick();

        // exception blocks the take
        irq_src = 4'b1011; tick();
        exception = 1;
        cmp_model();
        chk("s3_int", 32'(Interrupt), 32'd1);
        step();
        exception = 0; kernel_mode = 1; addr = BASE + IPEND_OFS;
        cmp_model();
        chk("s3_pend", rdata, 32'h2);
        chk("s3_kmode", 32'(Interrupt), 32'd0);
        addr = BASE + ICAUSE_OFS; #1;
        chk("s3_cause", rdata, 32'h8000_0003);
        step();
        kernel_mode = 0; tick();
        kernel_mode = 1; tick();
        kernel_mode = 0; tick();

        // lines high through reset do not trigger
        irq_src = 4'hF; reset = 1; tick(); tick();
        reset = 0; addr = BASE + IPEND_OFS; tick();
        cmp_model();
        chk("s4_pend0", rdata, 32'd0);
        irq_src = 4'b1011; tick();
        irq_src = 4'hF; tick();
        cmp_model();
        chk("s4_pend4", rdata, 32'h4);

        // set beats W1C in the same cycle
        wr_reg(IPEND_OFS, 32'h4);
        irq_src = 4'b1101; tick();
        irq_src = 4'hF;
        wr_reg(IPEND_OFS, 32'h2);
        addr = BASE + IPEND_OFS;
        cmp_model();
        chk("s5_setwins", rdata, 32'h2);
        wr_reg(IPEND_OFS, 32'h2);
        addr = BASE + IPEND_OFS;
        cmp_model();
        chk("s5_cleared", rdata, 32'd0);

        // reset while in service
        wr_reg(IMASK_OFS, 32'hF);
        irq_src = 4'hE; tick();
        irq_src = 4'hF; tick(); tick();
        kernel_mode = 1; irq_src = 4'h7; tick();
        irq_src = 4'hF; addr = BASE + IPEND_OFS; tick();
        cmp_model();
        chk("s6_pend8", rdata, 32'h8);
        reset = 1; tick();
        reset = 0; kernel_mode = 0;
        cmp_model();
        chk("s6_pend0", rdata, 32'd0);
        chk("s6_int", 32'(Interrupt), 32'd0);
        addr = BASE + IMASK_OFS; #1;
        chk("s6_mask0", rdata, 32'd0);
        step();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            irq_src     = irq_src ^ 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            kernel_mode = ($urandom_range(0, 3) == 0) ? ~kernel_mode : kernel_mode;
            exception   = $urandom_range(0, 7) == 0;
            wr          = $urandom_range(0, 3) == 0;
            wdata       = $urandom;
            reset       = $urandom_range(0, 199) == 0;
            case ($urandom_range(0, 4))
                0: addr = BASE + IMASK_OFS;
                1: addr = BASE + IPEND_OFS;
                2: addr = BASE + ICAUSE_OFS;
                3: addr = BASE + 12;
                default: addr = $urandom;
            endcase
            tick();
        end
        reset = 0; wr = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Interrupt controller for the single-cycle MIPS CPU. It latches edge-triggered requests from up to `N_SRC` peripherals (timer, UART RX/TX, switches) and masks and prioritises them. It drives the `Interrupt` input of the control decoder and tracks the in-service condition until the handler leaves kernel mode. Software reaches it through three memory-mapped registers on the data bus.

## Interface
Parameters:
- `N_SRC`, 4: number of interrupt sources, 1..8.
- `BASE_ADDR`, 32'h4000_0030: byte address of IMASK. IPEND is at +4, ICAUSE at +8.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `irq_src`  in  N_SRC  level request lines, synchronous to `clk`. A rising edge raises a request.
- `kernel_mode`  in  1  PC[31] of the current instruction.
- `exception`  in  1  the current instruction raises an exception (undefined opcode). It has precedence over interrupts.
- `Interrupt`  out  1  to the control decoder. When high, this cycle's instruction is replaced by interrupt entry.
- `addr`  in  32  data-bus address.
- `wdata`  in  32  data-bus write data.
- `wr`  in  1  bus write strobe.
- `rdata`  out  32  read data. Combinational; 0 when `addr` misses.

## Operation
- Edge detect: `irq_q <= irq_src` every cycle. `rise = irq_src & ~irq_q`. Reset loads `irq_q` to all ones, so lines already high at reset do not trigger.
- IMASK, `mask[N_SRC-1:0]`, read/write. Bit set means the source is enabled. Upper bits read 0.
- IPEND, `pend[N_SRC-1:0]`:
  - Each edge sets `pend |= rise`.
  - A write clears bits where `wdata` is 1 (W1C).
  - If a set and a W1C hit the same bit in the same cycle, the set wins.
- ICAUSE, read-only. [31] = valid, [2:0] = index of the last taken source.
- Priority: lowest index among `pend & mask` wins.
- FSM:
  - IDLE:
    - `Interrupt = ~kernel_mode & |(pend & mask)`.
    - Take condition: `Interrupt & ~exception`. On take, the state goes to SERVICE, `cause <= {1'b1, winner}`, and `pend[winner]` is cleared. A simultaneous edge on the same source keeps it set.
    - When `exception` is high, nothing changes. The request stays pending, and the resulting kernel entry gates it.
  - SERVICE:
    - `Interrupt = 0`.
    - Exit to IDLE on a kernel_mode falling edge (`kmode_q & ~kernel_mode`), i.e. the handler's `jr $k0` has retired.
    - New edges still set `pend`. `cause` is held.
- Writes to an unmapped `addr`, or to ICAUSE, are ignored.

## Timing
- Reset values: `Interrupt` 0, `rdata` 0 (when addr misses), `mask` 0, `pend` 0, `cause` 0, state IDLE, `kmode_q` 1, `irq_q` all ones.
- A source rising before edge k sets `pend` at edge k. `Interrupt` is high in the cycle after edge k, provided the source is unmasked, `kernel_mode` = 0 and the state is IDLE. The take happens at edge k+1, and `Interrupt` returns to 0 after it.
- A mask write at edge k affects `Interrupt` from the cycle after edge k.
- A second interrupt is raised no earlier than the cycle after the kernel_mode falling edge that ends SERVICE.
- Reset mid-SERVICE returns to IDLE and discards all pending requests.

## Structure
- Package `irq_pkg`: the state enum (IDLE, SERVICE), the register offsets `IMASK_OFS` = 0, `IPEND_OFS` = 4 and `ICAUSE_OFS` = 8, and the `CAUSE_VALID` bit position.
- One sub-module, `irq_prio_enc`: parameterised N_SRC-to-index priority encoder with an any-bit output. Combinational.
- The bus decode, registers and FSM stay in `irq_ctrl`.

## Test plan
- After reset, write IMASK = 4'b0101 and pulse `irq_src[2]` with `kernel_mode` = 0. Expect `pend` = 4'b0100, `Interrupt` high one cycle after the edge, then ICAUSE = 32'h8000_0002 and `pend` = 0.
- Raise `irq_src[3]` and `irq_src[0]` together with mask = 4'hF. Expect source 0 taken first. Then drop `kernel_mode` 1→0; source 3 is taken in the following IDLE cycle and ICAUSE = 32'h8000_0003.
- Pend source 1 with `exception` = 1 in the same cycle. Expect no take: `pend[1]` stays 1 and ICAUSE is unchanged. With `kernel_mode` = 1 the next cycle, `Interrupt` stays 0.
- Hold `irq_src` = 4'hF through reset release. Expect `pend` = 0. A single 0→1 pulse on source 2 then sets only bit 2.
- W1C IPEND = 4'b0010 in the same cycle as a new edge on source 1. Expect `pend[1]` = 1 (set wins). Writing 4'b0010 alone clears it.
- Assert `reset` while in SERVICE with `pend` = 4'b1000. Expect the state back to IDLE, `pend` = 0, `mask` = 0 and `Interrupt` = 0.
